regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug read-out engine for the 16-entry x 32-bit processor register file.
- On a start pulse it sweeps the register file's combinational read port across indices 0..NUM_REGS-1, one index at a time.
- Each captured word goes out on a valid/ready stream toward the debug/UART path.
- It is the reading counterpart to the core's writeback path: it uses the same address/data read-port contract and never writes.

Parameters:
- NUM_REGS, 16: number of registers swept; must be 2..2**ADDR_W.
- ADDR_W, 4: register address width.
- DATA_W, 32: register data width.
- R15_SUB, 1: when 1, the last index (NUM_REGS-1) outputs input r15 instead of rd_data.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  terminates the dump in READ/SEND; no done pulse.
- rd_addr  output  ADDR_W  address to the register file read port.
- rd_data  input  DATA_W  combinational read data for rd_addr.
- r15  input  DATA_W  PC-derived value substituted for the last index when R15_SUB=1.
- out_data  output  DATA_W  captured register value.
- out_idx  output  ADDR_W  register index of out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_last  output  1  high with out_valid on the final index.
- busy  output  1  high in READ, SEND and DONE.
- done  output  1  one-cycle pulse when a full sweep completes.

Behaviour:
- Reset (async assert, any state):
  - State goes to IDLE and the index counter to 0.
  - rd_addr, out_data, out_idx, out_valid, out_last, busy and done all go to 0.
  - Deassertion is synchronous to clk.
- rd_addr always equals the index counter.
- FSM states are IDLE, READ, SEND and DONE:
  - IDLE: start=1 -> index=0, go to READ. Otherwise stay.
  - READ: one cycle. Capture rd_data into out_data at the clock edge, or r15 if R15_SUB=1 and index==NUM_REGS-1. out_idx <= index. Go to SEND.
  - SEND: out_valid=1; out_last=1 iff index==NUM_REGS-1.
    - While out_ready=0: out_data, out_idx and out_last hold stable.
    - Transfer (out_valid & out_ready) on the last index: go to DONE.
    - Transfer on any other index: index+1, go to READ.
  - DONE: done=1 for exactly one cycle, index<=0, go to IDLE.
- Throughput: 2 cycles per register minimum; a full 16-register sweep takes 32 cycles from the first READ to the last transfer, plus 1 DONE cycle.
- out_valid is registered and asserts on the cycle after READ.
- No snapshot semantics: each register is sampled at its own READ cycle, so register-file writes during a sweep are visible for indices not yet read.
- start in READ/SEND/DONE: ignored, no queueing.
- abort in READ or SEND:
  - Next state IDLE; index, out_valid and out_last go to 0; done stays 0.
  - abort has priority over a simultaneous transfer.
  - abort in IDLE or DONE has no effect.
- start and abort together in IDLE: start wins.
- Index counter never exceeds NUM_REGS-1; no wrap-around is produced.

Test Plan:
- Registers preloaded with i*0x11111111, r15=0xDEAD_BEEF, out_ready tied 1, start pulse:
  - Output is 16 transfers, idx 0..15, data 0x00000000..0xEEEEEEEE for idx 0..14.
  - idx 15 carries 0xDEADBEEF with out_last=1.
  - done pulses 1 cycle, 33 cycles after the first READ cycle.
- Same sweep with out_ready toggling 1-in-3 -> out_data/out_idx hold stable while stalled; sequence identical; exactly 16 transfers.
- Register 5 written to 0x12345678 at the cycle before idx 5's READ -> idx 5 transfers 0x12345678.
- abort asserted while SEND holds idx 7 with out_ready=1 in the same cycle -> no transfer of idx 7, IDLE next cycle, done stays 0, a new start restarts at idx 0.
- rst asserted asynchronously mid-SEND -> all outputs 0 immediately, without a clock edge; after release, start gives a full clean sweep.
- start pulsed again during a sweep -> ignored; exactly 16 transfers and one done pulse.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: sweeps the register file read port over every index
// and streams each captured word (with its index) out on a valid/ready channel.
module regfile_dump_reader #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int R15_SUB  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] r15,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] out_idx_q;
  logic              is_last;

  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // abort outranks a transfer in the same SEND cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Each word is sampled in its own READ cycle, so later writes stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      out_idx_q <= '0;
    end else if (state_q == READ) begin
      data_q    <= ((R15_SUB != 0) && is_last) ? r15 : rd_data;
      out_idx_q <= idx_q;
    end
  end

  assign rd_addr   = idx_q;
  assign out_data  = data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && is_last;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words are queued per sweep
// from a register-file array model; a negedge monitor pops and compares transfers.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [3:0]  rd_addr, out_idx;
  logic [31:0] rd_data, r15, out_data;
  logic        out_valid, out_last, busy, done;

  logic [31:0] regs [16];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32), .R15_SUB(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .r15(r15),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int xfers, dones, busy_cnt, busy_at_done;
  int ready_mode = 0;
  int rcnt = 0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_idx;
  logic        hold_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = ready one cycle in three, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (rcnt % 3 == 0); rcnt++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        busy_at_done = busy_cnt;
      end
      if (hold_pending && out_valid) begin
        chk("stall_hold_data", out_data, hold_data);
        chk("stall_hold_idx", 32'(out_idx), 32'(hold_idx));
        chk("stall_hold_last", 32'(out_last), 32'(hold_last));
      end
      hold_pending = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx = out_idx;
      hold_last = out_last;
      if (out_valid && out_ready && !abort) begin
        exp_t e;
        xfers++;
        $display("xfer idx=%0d data=%h last=%0d", out_idx, out_data, out_last);
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'(out_idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_idx", 32'(out_idx), 32'(e.idx));
          chk("xfer_data", out_data, e.data);
          chk("xfer_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // Expected stream: one word per index, last index carries r15.
  task automatic push_expect(input int count, input int poke5);
    for (int i = 0; i < count; i++) begin
      exp_t e;
      e.idx  = 4'(i);
      e.data = (i == 15) ? r15 : ((poke5 != 0 && i == 5) ? 32'h1234_5678 : regs[i]);
      e.last = (i == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_sweep(input int mode, input int check33, input int poke5, input int restart_mid);
    int cyc;
    bit poked;
    bit restarted;
    ready_mode = mode;
    push_expect(16, poke5);
    xfers = 0; dones = 0; busy_cnt = 0; busy_at_done = 0;
    poked = 1'b0; restarted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (poke5 != 0 && !poked && rd_addr == 4'd4) begin
        regs[5] = 32'h1234_5678;
        poked = 1'b1;
      end
      if (restart_mid != 0 && !restarted && rd_addr == 4'd8) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (dones > 0) break;
    end
    if (cyc >= 2000) chk("sweep_timeout", 32'(dones), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("sweep_done_pulses", 32'(dones), 32'd1);
    chk("sweep_xfer_count", 32'(xfers), 32'd16);
    chk("sweep_queue_left", 32'(exp_q.size()), 32'd0);
    chk("sweep_idle_busy", 32'(busy), 32'd0);
    if (check33 != 0) chk("sweep_busy_cycles", 32'(busy_at_done), 32'd33);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    r15 = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) regs[i] = 32'(i) * 32'h1111_1111;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Preloaded sweep, always ready, then 1-in-3 ready
    do_sweep(0, 1, 0, 0);
    do_sweep(1, 0, 0, 0);

    // Register 5 rewritten mid-sweep, just before its READ
    regs[5] = 32'hAAAA_5555;
    do_sweep(0, 1, 1, 0);

    // abort while idx 7 is offered with out_ready high
    ready_mode = 0;
    push_expect(7, 0);
    xfers = 0; dones = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == 4'd7) break;
    end
    if (cyc >= 200) chk("abort_wait_timeout", 32'(cyc), 32'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    chk("abort_rd_addr", 32'(rd_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_xfers", 32'(xfers), 32'd7);
    chk("abort_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    do_sweep(0, 1, 0, 0);

    // Asynchronous reset in the middle of SEND
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    r15 = $urandom;
    ready_mode = 2;
    push_expect(16, 0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == 4'd3) break;
    end
    if (cyc >= 500) chk("rst_wait_timeout", 32'(cyc), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    do_sweep(2, 0, 0, 0);

    // start pulsed again mid-sweep must be ignored
    do_sweep(0, 1, 0, 1);

    // Random contents with random backpressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      r15 = $urandom;
      do_sweep(2, 0, 0, (k == 1) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
